// File: rtl/cp0_unit.sv
// cp0_unit: minimal MIPS coprocessor 0 holding SR, Cause, EPC and PRId. It raises the
// interrupt request and keeps the return PC for eret.
// Optional feature: define CP0_TIMER_EN to add Count/Compare and a timer interrupt on IP7.
module cp0_unit #(
  parameter logic [31:0] PRID = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  sel,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  input  logic [5:0]  hw_int,
  input  logic        exl_set,
  input  logic        exl_clr,
  input  logic [31:0] victim_pc,
  output logic [31:0] epc,
  output logic        int_req
);

  localparam logic [4:0] SelCount   = 5'd9;
  localparam logic [4:0] SelCompare = 5'd11;
  localparam logic [4:0] SelSr      = 5'd12;
  localparam logic [4:0] SelCause   = 5'd13;
  localparam logic [4:0] SelEpc     = 5'd14;
  localparam logic [4:0] SelPrid    = 5'd15;

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic [5:0]  ip_q, ip_d;
  logic [31:0] epc_q, epc_d;
  logic [5:0]  cause_ip;
  logic        wr_sr, wr_epc;

  assign wr_sr  = we && (sel == SelSr);
  assign wr_epc = we && (sel == SelEpc);

`ifdef CP0_TIMER_EN
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        pend_q, pend_d;
  logic        wr_count, wr_compare;

  assign wr_count   = we && (sel == SelCount);
  assign wr_compare = we && (sel == SelCompare);
  // The timer joins IP7 after the IP register so clearing it via Compare takes effect at once.
  assign cause_ip   = {ip_q[5] | pend_q, ip_q[4:0]};

  // Timer next state: a Count write replaces the increment, and a Compare write acks the timer.
  always_comb begin
    count_d   = wr_count ? wdata : count_q + 32'd1;
    compare_d = wr_compare ? wdata : compare_q;
    pend_d    = pend_q;
    if (wr_compare) begin
      pend_d = 1'b0;
    end else if ((count_q == compare_q) && (compare_q != 32'd0)) begin
      pend_d = 1'b1;
    end
  end

  // Timer state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      pend_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      pend_q    <= pend_d;
    end
  end
`else
  assign cause_ip = ip_q;
`endif

  // SR/EPC/IP next state: exl_set beats exl_clr, and both beat an mtc0 to EXL or EPC.
  always_comb begin
    im_d  = im_q;
    ie_d  = ie_q;
    exl_d = exl_q;
    epc_d = epc_q;
    ip_d  = hw_int;
    if (wr_sr) begin
      im_d  = wdata[15:10];
      ie_d  = wdata[0];
      exl_d = wdata[1];
    end
    if (wr_epc) begin
      epc_d = {wdata[31:2], 2'b00};
    end
    if (exl_clr) begin
      exl_d = 1'b0;
    end
    if (exl_set) begin
      exl_d = 1'b1;
      epc_d = {victim_pc[31:2], 2'b00};
    end
  end

  // Core state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im_q  <= 6'd0;
      ie_q  <= 1'b0;
      exl_q <= 1'b0;
      ip_q  <= 6'd0;
      epc_q <= 32'd0;
    end else begin
      im_q  <= im_d;
      ie_q  <= ie_d;
      exl_q <= exl_d;
      ip_q  <= ip_d;
      epc_q <= epc_d;
    end
  end

  // mfc0 read mux from current (pre-edge) state.
  always_comb begin
    rdata = 32'd0;
    case (sel)
`ifdef CP0_TIMER_EN
      SelCount:   rdata = count_q;
      SelCompare: rdata = compare_q;
`endif
      SelSr:      rdata = {16'd0, im_q, 8'd0, exl_q, ie_q};
      SelCause:   rdata = {16'd0, cause_ip, 10'd0};
      SelEpc:     rdata = epc_q;
      SelPrid:    rdata = PRID;
      default:    rdata = 32'd0;
    endcase
  end

  assign epc     = epc_q;
  assign int_req = (|(cause_ip & im_q)) & ie_q & ~exl_q;

endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: directed and randomized checks of cp0_unit against a register-level
// reference model. Define CP0_TIMER_EN to also exercise the timer.
module tb_cp0_unit;

  localparam logic [31:0] Prid = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  sel = 5'd0;
  logic [31:0] wdata = 32'd0;
  logic        we = 1'b0;
  logic [31:0] rdata;
  logic [5:0]  hw_int = 6'd0;
  logic        exl_set = 1'b0;
  logic        exl_clr = 1'b0;
  logic [31:0] victim_pc = 32'd0;
  logic [31:0] epc;
  logic        int_req;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural register values.
  logic [31:0] m_sr, m_epc, m_count, m_cmp;
  logic [5:0]  m_ip;
  logic        m_pend;

  cp0_unit #(.PRID(Prid)) dut (
    .clk       (clk),
    .reset     (reset),
    .sel       (sel),
    .wdata     (wdata),
    .we        (we),
    .rdata     (rdata),
    .hw_int    (hw_int),
    .exl_set   (exl_set),
    .exl_clr   (exl_clr),
    .victim_pc (victim_pc),
    .epc       (epc),
    .int_req   (int_req)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] m_ip_eff();
`ifdef CP0_TIMER_EN
    return {m_ip[5] | m_pend, m_ip[4:0]};
`else
    return m_ip;
`endif
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] s);
    case (s)
`ifdef CP0_TIMER_EN
      5'd9:  return m_count;
      5'd11: return m_cmp;
`endif
      5'd12: return m_sr;
      5'd13: return {16'd0, m_ip_eff(), 10'd0};
      5'd14: return m_epc;
      5'd15: return Prid;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_int();
    return (|(m_ip_eff() & m_sr[15:10])) & m_sr[0] & ~m_sr[1];
  endfunction

  task automatic m_reset();
    m_sr = 0; m_epc = 0; m_count = 0; m_cmp = 0; m_ip = 0; m_pend = 0;
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic m_step();
    logic [31:0] nsr, nepc;
    nsr  = m_sr;
    nepc = m_epc;
    if (we && sel == 5'd12) nsr = wdata & 32'h0000_FC03;
    if (we && sel == 5'd14) nepc = wdata & ~32'd3;
    if (exl_clr) nsr[1] = 1'b0;
    if (exl_set) begin
      nsr[1] = 1'b1;
      nepc   = victim_pc & ~32'd3;
    end
`ifdef CP0_TIMER_EN
    if (we && sel == 5'd11) m_pend = 1'b0;
    else if (m_count == m_cmp && m_cmp != 0) m_pend = 1'b1;
    m_count = (we && sel == 5'd9) ? wdata : m_count + 1;
    if (we && sel == 5'd11) m_cmp = wdata;
`endif
    m_sr  = nsr;
    m_epc = nepc;
    m_ip  = hw_int;
  endtask

  task automatic drive(input logic w, input logic [4:0] s, input logic [31:0] d,
                       input logic set, input logic clr, input logic [31:0] vpc);
    we = w; sel = s; wdata = d; exl_set = set; exl_clr = clr; victim_pc = vpc;
  endtask

  // Check outputs against the model mid-cycle, then take one edge.
  task automatic cycle(input string tag);
    #1;
    check({tag, ".rdata"}, rdata, m_read(sel));
    check({tag, ".int_req"}, {31'd0, int_req}, {31'd0, m_int()});
    check({tag, ".epc"}, epc, m_epc);
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  task automatic idle(input logic [4:0] s);
    drive(1'b0, s, 32'd0, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    int waited;
    logic [4:0] sels [7];
    sels[0] = 5'd9; sels[1] = 5'd11; sels[2] = 5'd12; sels[3] = 5'd13;
    sels[4] = 5'd14; sels[5] = 5'd15; sels[6] = 5'd3;
    m_reset();

    // Reset state, with write/exl inputs asserted while held in reset.
    drive(1'b1, 5'd14, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hABCD_0000);
    repeat (2) @(negedge clk);
    #1;
    check("rst.epc", epc, 32'd0);
    check("rst.int_req", {31'd0, int_req}, 32'd0);
    check("rst.rdata_epc", rdata, 32'd0);
    reset = 1'b1;
    idle(5'd12);

    // Level interrupt on IP2: one-cycle latency in and out.
    hw_int = 6'b000001;
    drive(1'b1, 5'd12, 32'h0000_0401, 1'b0, 1'b0, 32'd0);
    cycle("sr_wr");
    idle(5'd12);
    #1 check("irq_rise", {31'd0, int_req}, 32'd1);
    hw_int = 6'd0;
    cycle("irq_hold");
    #1 check("irq_fall", {31'd0, int_req}, 32'd0);

    // Interrupt entry and eret.
    hw_int = 6'b000001;
    cycle("irq_re");
    drive(1'b0, 5'd14, 32'd0, 1'b1, 1'b0, 32'h0000_3047);
    cycle("exl_set");
    idle(5'd12);
    #1;
    check("entry.epc", epc, 32'h0000_3044);
    check("entry.exl", {31'd0, rdata[1]}, 32'd1);
    check("entry.int_req", {31'd0, int_req}, 32'd0);
    cycle("in_handler");
    drive(1'b0, 5'd12, 32'd0, 1'b0, 1'b1, 32'd0);
    cycle("eret");
    idle(5'd12);
    #1;
    check("eret.exl", {31'd0, rdata[1]}, 32'd0);
    check("eret.int_req", {31'd0, int_req}, 32'd1);
    check("eret.epc", epc, 32'h0000_3044);

    // exl_set beats exl_clr and a same-cycle EPC write.
    drive(1'b1, 5'd14, 32'h0000_1234, 1'b1, 1'b1, 32'h0000_5557);
    cycle("prio");
    idle(5'd12);
    #1;
    check("prio.epc", epc, 32'h0000_5554);
    check("prio.exl", {31'd0, rdata[1]}, 32'd1);

    // Read mux: PRId, Cause with IP7|IP2, unimplemented register, ignored Cause write.
    hw_int = 6'b100001;
    drive(1'b1, 5'd13, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0);
    cycle("cause_wr");
    idle(5'd15);
    #1 check("rd.prid", rdata, Prid);
    sel = 5'd13;
    #1 check("rd.cause", rdata, 32'h0000_8400);
    sel = 5'd3;
    #1 check("rd.unimpl", rdata, 32'd0);
`ifndef CP0_TIMER_EN
    drive(1'b1, 5'd11, 32'h0000_0005, 1'b0, 1'b0, 32'd0);
    cycle("cmp_wr_off");
    idle(5'd11);
    #1 check("rd.cmp_off", rdata, 32'd0);
`endif
    cycle("post_rd");

    // Asynchronous reset mid-operation, away from any clock edge.
    #2 reset = 1'b0;
    #1;
    m_reset();
    check("arst.epc", epc, 32'd0);
    check("arst.int_req", {31'd0, int_req}, 32'd0);
    sel = 5'd12;
    #1 check("arst.sr", rdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    idle(5'd12);
    hw_int = 6'd0;

`ifdef CP0_TIMER_EN
    // Timer: Compare=5, Count=0, IM7+IE, then ack via a Compare write.
    drive(1'b1, 5'd11, 32'd5, 1'b0, 1'b0, 32'd0);
    cycle("t_cmp");
    drive(1'b1, 5'd9, 32'd0, 1'b0, 1'b0, 32'd0);
    cycle("t_cnt");
    drive(1'b1, 5'd12, 32'h0000_8001, 1'b0, 1'b0, 32'd0);
    cycle("t_sr");
    idle(5'd9);
    waited = 0;
    while (!int_req && waited < 7) begin
      cycle("t_wait");
      waited++;
    end
    check("timer_rise", {31'd0, int_req}, 32'd1);
    drive(1'b1, 5'd11, 32'd100, 1'b0, 1'b0, 32'd0);
    cycle("t_ack");
    idle(5'd13);
    #1 check("timer_ack", {31'd0, int_req}, 32'd0);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) hw_int = 6'($urandom());
      drive(($urandom_range(0, 3) == 0), sels[$urandom_range(0, 6)], $urandom(),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0), $urandom());
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp0_unit.md
CP0_UNIT -- requirements
Module: cp0_unit

Interface
REQ-001 SHALL have parameter PRID, default 32'h0000_3000, value returned when reading register 15 (PRId).
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port sel  in  5  CP0 register number (rd field) for read and write.
REQ-005 SHALL have port wdata  in  32  mtc0 write data.
REQ-006 SHALL have port we  in  1  mtc0 write enable (CP0Write from decode).
REQ-007 SHALL have port rdata  out  32  mfc0 read data, combinational from sel.
REQ-008 SHALL have port hw_int  in  6  external interrupt lines IP[7:2], level-sensitive.
REQ-009 SHALL have port exl_set  in  1  interrupt taken this cycle (ExlSet from controller).
REQ-010 SHALL have port exl_clr  in  1  eret retiring this cycle (ExlClr from controller).
REQ-011 SHALL have port victim_pc  in  32  PC of the instruction to resume at after the interrupt.
REQ-012 SHALL have port epc  out  32  current EPC, next-PC source for eret.
REQ-013 SHALL have port int_req  out  1  interrupt request to the controller (IntReq).

Function
REQ-014 SHALL implement SR (reg 12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
REQ-015 SHALL implement Cause (reg 13): IP[15:10], ExcCode[6:2] always 0; other bits read 0.
REQ-016 SHALL implement EPC (reg 14), bits [1:0] forced 0 on every write.
REQ-017 SHALL return PRID for sel=15 and 0 for any unimplemented sel.
REQ-018 SHALL register Cause.IP[7:2] from hw_int every cycle; IP7 is ORed with timer_pending when the timer is compiled in.
REQ-019 SHALL drive int_req = |(Cause.IP & SR.IM) & SR.IE & !SR.EXL, combinational from registered state; 1-cycle latency from hw_int to int_req.
REQ-020 SHALL, on exl_set, load EPC <= {victim_pc[31:2],2'b00} and set SR.EXL next edge.
REQ-021 SHALL, on exl_clr, clear SR.EXL next edge; EPC unchanged.
REQ-022 SHALL apply mtc0 when we=1 to SR, EPC or (timer) Count/Compare; writes to Cause and PRId are ignored.
REQ-023 SHALL give priority exl_set > exl_clr for EXL when both are asserted in one cycle.
REQ-024 SHALL give priority exl_set over a same-cycle mtc0 to EPC or to SR.EXL; the remaining SR fields take wdata.
REQ-025 SHALL keep int_req low in the cycle after exl_set (EXL=1), with no re-entry until exl_clr.
REQ-026 SHALL present rdata from pre-edge state; no internal write-to-read bypass.

Reset
REQ-027 SHALL on reset low asynchronously clear SR, Cause.IP, EPC, Count and Compare, and timer_pending, giving int_req=0 and epc=0.
REQ-028 SHALL ignore exl_set, exl_clr and we while reset is low; operation resumes on the first edge after release.

Configuration
REQ-029 SHALL use macro CP0_TIMER_EN to compile in the timer; it is absent by default.
REQ-030 With CP0_TIMER_EN: Count (reg 9) +1 per cycle, wrapping 32'hFFFF_FFFF->0; Compare (reg 11) read/write.
REQ-031 With CP0_TIMER_EN: timer_pending is set on the edge after Count==Compare (Compare!=0) and is cleared by an mtc0 to Compare; a write to Count loads wdata in place of the increment.
REQ-032 Without CP0_TIMER_EN: regs 9/11 read 0, writes are ignored, and IP7 = hw_int[5] only.

Verification
REQ-033 SR<=32'h0000_0401, hw_int=6'b000001 -> int_req=1 next cycle; hw_int=0 -> int_req=0 the cycle after.
REQ-034 int_req=1, exl_set with victim_pc=32'h0000_3047 -> EPC=32'h0000_3044, SR.EXL=1, int_req=0; exl_clr -> EXL=0, int_req=1 again while hw_int is still high.
REQ-035 Same-cycle exl_set+exl_clr+mtc0 EPC=32'h1234 -> EXL=1, EPC=victim_pc aligned.
REQ-036 mfc0 sel=15 -> PRID; sel=13 with hw_int=6'b100001 -> 32'h0000_8400; sel=3 -> 0.
REQ-037 Reset pulsed low mid-operation (EXL=1, EPC set) -> all registers 0 and int_req=0 immediately, without waiting for a clock edge.
REQ-038 CP0_TIMER_EN: Compare<=5, Count<=0, IM7=1, IE=1 -> int_req rises within 7 cycles; mtc0 to Compare -> int_req=0 next cycle.
